// File: rtl/apb_rr_master_arbiter_pkg.sv
// Shared definitions for the round-robin APB master arbiter.
//   arb_state_e : transfer FSM states (IDLE, SETUP, ACCESS, DONE)
//   grant_idx_t : grant index wide enough for the largest supported NB_REQ (8)
//   cnt_width() : watchdog counter width for a given timeout, never below 1 bit
package apb_rr_master_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

  localparam int unsigned MAX_REQ = 8;

  typedef logic [$clog2(MAX_REQ)-1:0] grant_idx_t;

  // A timeout of 0 disables the watchdog; keep a 1-bit counter so the
  // declaration stays legal.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_rr_master_arbiter_if.sv
// Bus bundle for the round-robin APB master arbiter.
//   req_* : NB_REQ requester-side APB slave ports (arbiter is the slave here)
//   m_*   : single downstream APB master port toward the peripheral bus
// Modports:
//   master : arbiter view (drives completion strobes and the downstream bus)
//   slave  : environment view (requesters plus the downstream peripheral)
interface apb_rr_master_arbiter_if #(
  parameter int unsigned NB_REQ = 3,
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32
);

  logic [NB_REQ-1:0]         req_psel_i;
  logic [NB_REQ-1:0]         req_penable_i;
  logic [NB_REQ-1:0]         req_pwrite_i;
  logic [NB_REQ-1:0][AW-1:0] req_paddr_i;
  logic [NB_REQ-1:0][DW-1:0] req_pwdata_i;
  logic [DW-1:0]             req_prdata_o;
  logic [NB_REQ-1:0]         req_pready_o;
  logic [NB_REQ-1:0]         req_pslverr_o;

  logic [AW-1:0]             m_paddr_o;
  logic [DW-1:0]             m_pwdata_o;
  logic                      m_pwrite_o;
  logic                      m_psel_o;
  logic                      m_penable_o;
  logic [DW-1:0]             m_prdata_i;
  logic                      m_pready_i;
  logic                      m_pslverr_i;

  modport master (
    input  req_psel_i, req_penable_i, req_pwrite_i, req_paddr_i, req_pwdata_i,
    output req_prdata_o, req_pready_o, req_pslverr_o,
    output m_paddr_o, m_pwdata_o, m_pwrite_o, m_psel_o, m_penable_o,
    input  m_prdata_i, m_pready_i, m_pslverr_i
  );

  modport slave (
    output req_psel_i, req_penable_i, req_pwrite_i, req_paddr_i, req_pwdata_i,
    input  req_prdata_o, req_pready_o, req_pslverr_o,
    input  m_paddr_o, m_pwdata_o, m_pwrite_o, m_psel_o, m_penable_o,
    output m_prdata_i, m_pready_i, m_pslverr_i
  );

endinterface

// File: rtl/apb_rr_master_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req       : request vector
//   ptr       : index of the last winner; search starts at ptr+1 (mod N)
//   gnt_oh    : one-hot winner
//   gnt_idx   : binary winner index
//   gnt_valid : at least one request present
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt_oh,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_valid
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] cand;

  // Walk distances 1..N from the pointer so the last winner is checked last.
  always_comb begin
    gnt_oh    = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    for (int unsigned d = 1; d <= N; d++) begin
      cand = IW'((32'(ptr) + d) % N);
      if (!gnt_valid && req[cand]) begin
        gnt_valid    = 1'b1;
        gnt_idx      = cand;
        gnt_oh[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_rr_master_arbiter.sv
// Shares one downstream APB port between NB_REQ APB masters.
// Grants are round-robin and held for one complete transfer; a watchdog
// terminates transfers whose slave never raises PREADY.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : requester ports and downstream APB master (master modport)
//   busy_o       : FSM is not IDLE
//   grant_o      : index of the requester owning the downstream bus
//   timeout_o    : one-cycle pulse when the watchdog ends a transfer
module apb_rr_master_arbiter
  import apb_rr_master_arbiter_pkg::*;
#(
  parameter int unsigned NB_REQ         = 3,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  apb_rr_master_arbiter_if.master   bus,
  output logic                      busy_o,
  output logic [$clog2(NB_REQ)-1:0] grant_o,
  output logic                      timeout_o
);

  localparam int unsigned GW = $clog2(NB_REQ);
  localparam int unsigned CW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES);

  arb_state_e        state;
  logic [GW-1:0]     ptr;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_inc;
  logic [NB_REQ-1:0] grant_oh_q;

  logic [NB_REQ-1:0] gnt_oh;
  logic [GW-1:0]     gnt_idx;
  logic              gnt_valid;

  // PENABLE from requesters carries no information the arbiter needs.
  logic unused_penable;
  assign unused_penable = ^bus.req_penable_i;

  assign cnt_inc = cnt + CW'(1);

  rr_arbiter #(
    .N (NB_REQ)
  ) u_rr (
    .req       (bus.req_psel_i),
    .ptr       (ptr),
    .gnt_oh    (gnt_oh),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state             <= IDLE;
      ptr               <= GW'(NB_REQ - 1);
      cnt               <= '0;
      grant_oh_q        <= '0;
      grant_o           <= '0;
      busy_o            <= 1'b0;
      timeout_o         <= 1'b0;
      bus.m_paddr_o     <= '0;
      bus.m_pwdata_o    <= '0;
      bus.m_pwrite_o    <= 1'b0;
      bus.m_psel_o      <= 1'b0;
      bus.m_penable_o   <= 1'b0;
      bus.req_prdata_o  <= '0;
      bus.req_pready_o  <= '0;
      bus.req_pslverr_o <= '0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            bus.m_paddr_o  <= bus.req_paddr_i[gnt_idx];
            bus.m_pwdata_o <= bus.req_pwdata_i[gnt_idx];
            bus.m_pwrite_o <= bus.req_pwrite_i[gnt_idx];
            bus.m_psel_o   <= 1'b1;
            grant_o        <= gnt_idx;
            grant_oh_q     <= gnt_oh;
            ptr            <= gnt_idx;
            busy_o         <= 1'b1;
            state          <= SETUP;
          end
        end
        SETUP: begin
          bus.m_penable_o <= 1'b1;
          cnt             <= '0;
          state           <= ACCESS;
        end
        ACCESS: begin
          if (bus.m_pready_i) begin
            bus.req_prdata_o  <= bus.m_pwrite_o ? '0 : bus.m_prdata_i;
            bus.req_pready_o  <= grant_oh_q;
            bus.req_pslverr_o <= grant_oh_q & {NB_REQ{bus.m_pslverr_i}};
            bus.m_psel_o      <= 1'b0;
            bus.m_penable_o   <= 1'b0;
            state             <= DONE;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt_inc == TIMEOUT_LAST)) begin
            // ACCESS has lasted TIMEOUT_CYCLES cycles without PREADY.
            bus.req_prdata_o  <= '0;
            bus.req_pready_o  <= grant_oh_q;
            bus.req_pslverr_o <= grant_oh_q;
            bus.m_psel_o      <= 1'b0;
            bus.m_penable_o   <= 1'b0;
            timeout_o         <= 1'b1;
            state             <= DONE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        DONE: begin
          bus.req_pready_o  <= '0;
          bus.req_pslverr_o <= '0;
          busy_o            <= 1'b0;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
module tb_apb_rr_master_arbiter;

  localparam int NB = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [1:0] grant;
  logic       tmo;

  int checks = 0;
  int errors = 0;
  int last_winner;

  logic [31:0] r_addr  [NB];
  logic [31:0] r_wdata [NB];
  logic        r_write [NB];
  logic [NB-1:0] pend;

  apb_rr_master_arbiter_if #(.NB_REQ(NB), .AW(AW), .DW(DW)) bus ();

  apb_rr_master_arbiter #(
    .NB_REQ         (NB),
    .APB_ADDR_WIDTH (AW),
    .APB_DATA_WIDTH (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus       (bus),
    .busy_o    (busy),
    .grant_o   (grant),
    .timeout_o (tmo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Spec rule: first requester found walking from last winner + 1 upward, modulo NB.
  function automatic int rr_pick(input logic [NB-1:0] p, input int last);
    int idx;
    for (int d = 1; d <= NB; d++) begin
      idx = (last + d) % NB;
      if (p[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] w, input logic wr);
    r_addr[i]  = a;
    r_wdata[i] = w;
    r_write[i] = wr;
    bus.req_paddr_i[i]  = a;
    bus.req_pwdata_i[i] = w;
    bus.req_pwrite_i[i] = wr;
    bus.req_psel_i[i]   = 1'b1;
    pend[i] = 1'b1;
  endtask

  task automatic drop_req(input int i);
    bus.req_psel_i[i] = 1'b0;
    pend[i] = 1'b0;
  endtask

  // Waits for the downstream transfer, plays the slave with `waits` wait
  // states, and checks the completion seen by the granted requester.
  task automatic do_xfer(input string tag, input int g, input int waits,
                         input logic [31:0] rd, input logic err);
    int  n;
    int  k;
    int  lat;
    int  ac;
    logic to;
    logic [NB-1:0] oh;
    n = 0;
    while (bus.m_psel_o !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    chk({tag, " psel_rise"}, bus.m_psel_o, 1'b1);
    if (bus.m_psel_o !== 1'b1) return;
    chk({tag, " grant"}, grant, g);
    chk({tag, " setup_penable"}, bus.m_penable_o, 1'b0);
    chk({tag, " paddr"}, bus.m_paddr_o, r_addr[g]);
    chk({tag, " pwdata"}, bus.m_pwdata_o, r_wdata[g]);
    chk({tag, " pwrite"}, bus.m_pwrite_o, r_write[g]);
    to = (TO != 0) && (waits >= TO);
    ac = to ? TO : waits + 1;
    k = 0;
    bus.m_prdata_i  = rd;
    bus.m_pslverr_i = err;
    for (lat = 1; lat <= 16; lat++) begin
      step();
      if (bus.req_pready_o != '0) break;
      chk({tag, " paddr_hold"}, bus.m_paddr_o, r_addr[g]);
      chk({tag, " pwdata_hold"}, bus.m_pwdata_o, r_wdata[g]);
      if (bus.m_penable_o === 1'b1) begin
        k++;
        bus.m_pready_i = (k == waits + 1);
      end else begin
        bus.m_pready_i = 1'b0;
      end
    end
    bus.m_pready_i  = 1'b0;
    bus.m_pslverr_i = 1'b0;
    oh = '0;
    oh[g] = 1'b1;
    chk({tag, " latency"}, lat, ac + 1);
    chk({tag, " req_pready"}, bus.req_pready_o, oh);
    chk({tag, " req_prdata"}, bus.req_prdata_o, (to || r_write[g]) ? 32'h0 : rd);
    chk({tag, " req_pslverr"}, bus.req_pslverr_o, (to || err) ? oh : '0);
    chk({tag, " timeout"}, tmo, to);
    chk({tag, " done_psel"}, bus.m_psel_o, 1'b0);
    chk({tag, " done_busy"}, busy, 1'b1);
  endtask

  initial begin
    int g;
    int w;
    logic [31:0] rd;
    logic e;
    int grants [NB];
    int seq [4];
    seq = '{0, 1, 2, 0};
    pend = '0;
    bus.req_psel_i    = '0;
    bus.req_penable_i = '0;
    bus.req_pwrite_i  = '0;
    bus.req_paddr_i   = '0;
    bus.req_pwdata_i  = '0;
    bus.m_prdata_i    = '0;
    bus.m_pready_i    = 1'b0;
    bus.m_pslverr_i   = 1'b0;
    for (int i = 0; i < NB; i++) grants[i] = 0;

    // Reset state
    repeat (3) step();
    chk("rst m_psel", bus.m_psel_o, 1'b0);
    chk("rst m_penable", bus.m_penable_o, 1'b0);
    chk("rst m_pwrite", bus.m_pwrite_o, 1'b0);
    chk("rst m_paddr", bus.m_paddr_o, 32'h0);
    chk("rst m_pwdata", bus.m_pwdata_o, 32'h0);
    chk("rst req_pready", bus.req_pready_o, 3'b000);
    chk("rst req_pslverr", bus.req_pslverr_o, 3'b000);
    chk("rst req_prdata", bus.req_prdata_o, 32'h0);
    chk("rst busy", busy, 1'b0);
    chk("rst grant", grant, 2'd0);
    chk("rst timeout", tmo, 1'b0);
    rst = 1'b0;
    step();

    // Single read from requester 0, zero-wait slave: N+1 / N+2 / N+3
    set_req(0, 32'h0000_1000, 32'h0, 1'b0);
    step();
    chk("t1 psel_n1", bus.m_psel_o, 1'b1);
    chk("t1 penable_n1", bus.m_penable_o, 1'b0);
    chk("t1 busy_n1", busy, 1'b1);
    chk("t1 grant", grant, 2'd0);
    step();
    chk("t1 penable_n2", bus.m_penable_o, 1'b1);
    bus.m_pready_i = 1'b1;
    bus.m_prdata_i = 32'hCAFE_0001;
    step();
    bus.m_pready_i = 1'b0;
    chk("t1 req_pready_n3", bus.req_pready_o, 3'b001);
    chk("t1 req_prdata", bus.req_prdata_o, 32'hCAFE_0001);
    chk("t1 req_pslverr", bus.req_pslverr_o, 3'b000);
    chk("t1 done_psel", bus.m_psel_o, 1'b0);
    drop_req(0);
    step();
    chk("t1 pready_clear", bus.req_pready_o, 3'b000);
    chk("t1 idle_busy", busy, 1'b0);

    // All three requesting from reset: grant order 0,1,2,0
    rst = 1'b1;
    set_req(0, 32'h0000_0100, 32'h1111_0000, 1'b0);
    set_req(1, 32'h0000_0200, 32'h2222_0000, 1'b1);
    set_req(2, 32'h0000_0300, 32'h3333_0000, 1'b0);
    step();
    rst = 1'b0;
    for (int t = 0; t < 4; t++) do_xfer("t2", seq[t], 0, $urandom, 1'b0);
    drop_req(0); drop_req(1); drop_req(2);
    step();
    last_winner = 0;

    // Write with 3 wait states; address/data must hold, done at N+6
    set_req(2, 32'h1A10_2000, 32'hDEAD_BEEF, 1'b1);
    do_xfer("t3", 2, 3, 32'h5555_AAAA, 1'b0);
    drop_req(2);
    step();
    last_winner = 2;

    // Slave never answers: watchdog fires
    set_req(0, 32'h0000_4000, 32'h0, 1'b0);
    do_xfer("t4", 0, 100, 32'h7777_7777, 1'b0);
    drop_req(0);
    step();
    chk("t4 timeout_pulse_end", tmo, 1'b0);
    last_winner = 0;

    // Downstream PSLVERR forwarded with PREADY
    set_req(1, 32'h0000_5000, 32'h0, 1'b0);
    do_xfer("t5", 1, 0, 32'h1234_5678, 1'b1);
    drop_req(1);
    step();
    last_winner = 1;

    // Reset during ACCESS, then a fresh request is served
    set_req(2, 32'h0000_6000, 32'h0, 1'b0);
    for (int n = 0; n < 6 && bus.m_penable_o !== 1'b1; n++) step();
    chk("t6 in_access", bus.m_penable_o, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6 rst_psel", bus.m_psel_o, 1'b0);
    chk("t6 rst_penable", bus.m_penable_o, 1'b0);
    chk("t6 rst_busy", busy, 1'b0);
    chk("t6 rst_pready", bus.req_pready_o, 3'b000);
    last_winner = NB - 1;
    do_xfer("t6", 2, 1, 32'h0BAD_F00D, 1'b0);
    drop_req(2);
    last_winner = 2;

    // Randomized traffic against the round-robin model
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NB; i++)
        if (!pend[i] && ($urandom_range(0, 1) == 1))
          set_req(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
      if (pend == '0) begin
        g = int'($urandom_range(0, NB - 1));
        set_req(g, $urandom, $urandom, 1'($urandom_range(0, 1)));
      end
      g  = rr_pick(pend, last_winner);
      w  = int'($urandom_range(0, 5));
      rd = $urandom;
      e  = ($urandom_range(0, 3) == 0);
      do_xfer("rnd", g, w, rd, e);
      grants[g]++;
      drop_req(g);
      last_winner = g;
    end
    for (int i = 0; i < NB; i++) drop_req(i);
    repeat (3) step();
    chk("end busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
